// File: rtl/multichan_link.sv
// multichan_link: multiplexes 2**CHANNEL_BIT fixed-width message channels over one byte UART link.
// Define MULTICHAN_LINK_RR_EN for round-robin TX arbitration; by default the lowest channel wins.

module multichan_link_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rdata   = mem[rd_ptr];

    // NOTE: registers update with <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers define validity and this keeps it RAM-mappable.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

module multichan_link #(
    parameter int CHANNEL_BIT = 1,
    parameter int MESSAGE_BIT = 72,
    parameter int LENGTH_BIT  = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                CLK,
    input  logic                                RST,
    output logic                                send_flag,
    output logic [7:0]                          send_data,
    output logic                                recv_flag,
    input  logic [7:0]                          recv_data,
    input  logic                                sendable,
    input  logic                                recvable,
    input  logic [2**CHANNEL_BIT-1:0]           read_flag,
    output logic [LENGTH_BIT+MESSAGE_BIT-1:0]   read_data,
    input  logic [2**CHANNEL_BIT-1:0]           write_flag,
    input  logic [LENGTH_BIT+MESSAGE_BIT-1:0]   write_data,
    output logic [2**CHANNEL_BIT-1:0]           readable,
    output logic [2**CHANNEL_BIT-1:0]           writable
);
    localparam int NCH      = 2**CHANNEL_BIT;
    localparam int MAXLEN   = MESSAGE_BIT / 8;
    localparam int WORD_BIT = LENGTH_BIT + MESSAGE_BIT;

    typedef enum logic {RX_HDR, RX_BODY} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_BODY} tx_state_t;

    logic [NCH-1:0]      rx_push, rx_pop, rx_empty, rx_full;
    logic [NCH-1:0]      tx_pop, tx_empty, tx_full;
    logic [WORD_BIT-1:0] rx_rdata [NCH];
    logic [WORD_BIT-1:0] tx_rdata [NCH];
    logic [WORD_BIT-1:0] rx_word, tx_word, tx_head;

    // ---------------- receive parser ----------------
    rx_state_t              rx_state;
    logic [2:0]             rx_ch;
    logic [4:0]             rx_len, rx_cnt;
    logic [MESSAGE_BIT-1:0] rx_payload, rx_next_payload;
    logic [2:0]             rx_done_ch;
    logic [4:0]             rx_done_len;
    logic                   rx_done, rx_accept;

    // The UART RX FIFO is first-word-fall-through, so every offered byte is taken immediately.
    assign recv_flag = recvable && !RST;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rx_done         = 1'b0;
        rx_done_ch      = rx_ch;
        rx_done_len     = rx_len;
        rx_next_payload = rx_payload;
        for (int j = 0; j < MAXLEN; j++) begin
            if (rx_cnt == 5'(j)) rx_next_payload[8*j +: 8] = recv_data;
        end
        if (recvable) begin
            if (rx_state == RX_HDR) begin
                rx_done_ch      = recv_data[7:5];
                rx_done_len     = recv_data[4:0];
                rx_next_payload = '0;
                rx_done         = (recv_data[4:0] == 5'd0);
            end else begin
                rx_done = (rx_cnt == rx_len - 5'd1);
            end
        end
    end

    // Oversized or misaddressed frames are still parsed to stay in sync, just never stored.
    assign rx_accept = rx_done && (int'(rx_done_ch) < NCH) && (rx_done_len <= 5'(MAXLEN))
                       && !rx_full[rx_done_ch[CHANNEL_BIT-1:0]];
    assign rx_word   = {LENGTH_BIT'(rx_done_len), rx_next_payload};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_state   <= RX_HDR;
            rx_ch      <= '0;
            rx_len     <= '0;
            rx_cnt     <= '0;
            rx_payload <= '0;
        end else if (recvable) begin
            case (rx_state)
                RX_HDR: begin
                    rx_ch      <= recv_data[7:5];
                    rx_len     <= recv_data[4:0];
                    rx_cnt     <= '0;
                    rx_payload <= '0;
                    if (recv_data[4:0] != 5'd0) rx_state <= RX_BODY;
                end
                default: begin
                    rx_payload <= rx_next_payload;
                    rx_cnt     <= rx_cnt + 5'd1;
                    if (rx_done) rx_state <= RX_HDR;
                end
            endcase
        end
    end

    // ---------------- read side ----------------
    logic [CHANNEL_BIT-1:0] rd_sel;
    logic                   rd_any;

    always_comb begin
        rd_sel  = '0;
        rd_any  = 1'b0;
        rx_push = '0;
        rx_pop  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!rx_empty[i]) begin
                rd_sel = CHANNEL_BIT'(i);
                rd_any = 1'b1;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            rx_push[i] = rx_accept && (rx_done_ch[CHANNEL_BIT-1:0] == CHANNEL_BIT'(i));
            rx_pop[i]  = rd_any && (rd_sel == CHANNEL_BIT'(i)) && read_flag[i];
        end
    end

    assign read_data = rd_any ? rx_rdata[rd_sel] : '0;
    assign readable  = ~rx_empty;
    assign writable  = ~tx_full;

    // ---------------- transmit queueing and arbitration ----------------
    logic [LENGTH_BIT-1:0]  wr_len;
    logic [CHANNEL_BIT-1:0] tx_sel;
    logic                   tx_any;

    assign wr_len  = write_data[WORD_BIT-1 -: LENGTH_BIT];
    assign tx_word = {(wr_len > LENGTH_BIT'(MAXLEN)) ? LENGTH_BIT'(MAXLEN) : wr_len,
                      write_data[MESSAGE_BIT-1:0]};
    assign tx_head = tx_rdata[tx_sel];

`ifdef MULTICHAN_LINK_RR_EN
    logic [CHANNEL_BIT-1:0] tx_last, tx_cand;

    // Search starts just after the last served channel; that channel itself comes last.
    always_comb begin
        tx_sel  = '0;
        tx_any  = 1'b0;
        tx_cand = '0;
        for (int k = NCH; k >= 1; k--) begin
            tx_cand = tx_last + CHANNEL_BIT'(k);
            if (!tx_empty[tx_cand]) begin
                tx_sel = tx_cand;
                tx_any = 1'b1;
            end
        end
    end
`else
    always_comb begin
        tx_sel = '0;
        tx_any = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!tx_empty[i]) begin
                tx_sel = CHANNEL_BIT'(i);
                tx_any = 1'b1;
            end
        end
    end
`endif

    // ---------------- serializer ----------------
    tx_state_t              tx_state;
    logic [CHANNEL_BIT-1:0] tx_ch;
    logic [4:0]             tx_len, tx_cnt;
    logic [MESSAGE_BIT-1:0] tx_shift;

    always_comb begin
        tx_pop = '0;
        for (int i = 0; i < NCH; i++) begin
            tx_pop[i] = (tx_state == TX_IDLE) && sendable && tx_any && (tx_sel == CHANNEL_BIT'(i));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_state  <= TX_IDLE;
            tx_ch     <= '0;
            tx_len    <= '0;
            tx_cnt    <= '0;
            tx_shift  <= '0;
            send_flag <= 1'b0;
            send_data <= '0;
`ifdef MULTICHAN_LINK_RR_EN
            tx_last   <= CHANNEL_BIT'(NCH - 1);
`endif
        end else begin
            send_flag <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (sendable && tx_any) begin
                        tx_ch    <= tx_sel;
                        tx_len   <= 5'(tx_head[WORD_BIT-1 -: LENGTH_BIT]);
                        tx_shift <= tx_head[MESSAGE_BIT-1:0];
                        tx_state <= TX_HDR;
`ifdef MULTICHAN_LINK_RR_EN
                        tx_last  <= tx_sel;
`endif
                    end
                end
                TX_HDR: begin
                    if (sendable) begin
                        send_flag <= 1'b1;
                        send_data <= {3'(tx_ch), tx_len};
                        tx_cnt    <= '0;
                        tx_state  <= (tx_len == 5'd0) ? TX_IDLE : TX_BODY;
                    end
                end
                default: begin
                    if (sendable) begin
                        send_flag <= 1'b1;
                        send_data <= tx_shift[7:0];
                        tx_shift  <= tx_shift >> 8;
                        tx_cnt    <= tx_cnt + 5'd1;
                        if (tx_cnt == tx_len - 5'd1) tx_state <= TX_IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------- per-channel message FIFOs ----------------
    for (genvar g = 0; g < NCH; g++) begin : g_chan
        multichan_link_fifo #(.WIDTH(WORD_BIT), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
            .CLK   (CLK),
            .RST   (RST),
            .push  (rx_push[g]),
            .pop   (rx_pop[g]),
            .wdata (rx_word),
            .rdata (rx_rdata[g]),
            .empty (rx_empty[g]),
            .full  (rx_full[g])
        );
        multichan_link_fifo #(.WIDTH(WORD_BIT), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
            .CLK   (CLK),
            .RST   (RST),
            .push  (write_flag[g]),
            .pop   (tx_pop[g]),
            .wdata (tx_word),
            .rdata (tx_rdata[g]),
            .empty (tx_empty[g]),
            .full  (tx_full[g])
        );
    end
endmodule

// File: tb/tb_multichan_link.sv
// Scoreboard bench for multichan_link: queue-level reference model, randomized RX/TX traffic.
// Honours MULTICHAN_LINK_RR_EN to switch the expected TX arbitration order.

module tb_multichan_link;
    localparam int CHANNEL_BIT = 1;
    localparam int NCH         = 2;
    localparam int MESSAGE_BIT = 72;
    localparam int LENGTH_BIT  = 5;
    localparam int FIFO_DEPTH  = 4;
    localparam int MAXLEN      = 9;
    localparam int W           = LENGTH_BIT + MESSAGE_BIT;

    logic           CLK = 1'b0;
    logic           RST;
    logic           send_flag, recv_flag, sendable, recvable;
    logic [7:0]     send_data, recv_data;
    logic [NCH-1:0] read_flag, write_flag, readable, writable;
    logic [W-1:0]   read_data, write_data;

    multichan_link #(
        .CHANNEL_BIT (CHANNEL_BIT),
        .MESSAGE_BIT (MESSAGE_BIT),
        .LENGTH_BIT  (LENGTH_BIT),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .send_flag  (send_flag),
        .send_data  (send_data),
        .recv_flag  (recv_flag),
        .recv_data  (recv_data),
        .sendable   (sendable),
        .recvable   (recvable),
        .read_flag  (read_flag),
        .read_data  (read_data),
        .write_flag (write_flag),
        .write_data (write_data),
        .readable   (readable),
        .writable   (writable)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;

    logic [W-1:0] exp_rx0[$], exp_rx1[$];
    logic [W-1:0] mdl_tx0[$], mdl_tx1[$];
    logic [7:0]   exp_tx[$];
    int           rr_last = NCH - 1;
    bit           rx_drain = 1'b0;
    bit           tx_mon_en = 1'b1;
    bit           prev_sendable;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [71:0] rand72();
        return 72'({$urandom(), $urandom(), $urandom()});
    endfunction

    // RX monitor: pops the presented message and scores it; sometimes sets a non-presented read bit.
    initial begin
        read_flag = '0;
        forever begin
            @(negedge CLK);
            read_flag = '0;
            if (!RST) begin
                if (recvable || recv_flag) check("recv_flag", recv_flag, recvable);
                if (rx_drain && readable != '0) begin
                    check("readable", readable, {exp_rx1.size() != 0, exp_rx0.size() != 0});
                    if (readable[0]) begin
                        if (exp_rx0.size() != 0) check("rx_ch0_data", read_data, exp_rx0.pop_front());
                        read_flag = {1'($urandom_range(1)), 1'b1};
                    end else begin
                        if (exp_rx1.size() != 0) check("rx_ch1_data", read_data, exp_rx1.pop_front());
                        read_flag = 2'b10;
                    end
                end
            end
        end
    end

    // TX monitor: every strobed byte must be the next expected one and follow a sendable cycle.
    initial begin
        prev_sendable = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST && tx_mon_en && send_flag) begin
                check("send_after_sendable", prev_sendable, 1'b1);
                if (exp_tx.size() == 0) begin
                    checks++;
                    $display("FAIL tx_extra_byte: got %02h, expected no byte", send_data);
                end else begin
                    check("tx_byte", send_data, exp_tx.pop_front());
                end
            end
            prev_sendable = sendable;
        end
    end

    task automatic feed_byte(input logic [7:0] b);
        recvable  = 1'b1;
        recv_data = b;
        @(posedge CLK); #1;
        recvable = 1'b0;
        if ($urandom_range(3) == 0) begin
            @(posedge CLK); #1;
        end
    endtask

    // Sends one framed message and records what the receiver must keep.
    task automatic rx_msg(input logic [2:0] ch, input logic [4:0] len, input logic [71:0] pl);
        logic [71:0] stored = '0;
        logic [7:0]  b;
        feed_byte({ch, len});
        for (int k = 0; k < int'(len); k++) begin
            b = (k < MAXLEN) ? pl[8*k +: 8] : 8'($urandom());
            if (k < MAXLEN) stored[8*k +: 8] = b;
            feed_byte(b);
        end
        if (int'(ch) < NCH && int'(len) <= MAXLEN) begin
            if (ch == 3'd0 && exp_rx0.size() < FIFO_DEPTH) exp_rx0.push_back({len, stored});
            if (ch == 3'd1 && exp_rx1.size() < FIFO_DEPTH) exp_rx1.push_back({len, stored});
        end
    endtask

    task automatic rx_drain_all();
        int t = 0;
        rx_drain = 1'b1;
        while ((exp_rx0.size() + exp_rx1.size()) != 0 && t < 200) begin
            @(posedge CLK); #1;
            t++;
        end
        repeat (3) @(posedge CLK);
        #1;
        rx_drain = 1'b0;
        @(negedge CLK);
        check("rx_leftover", exp_rx0.size() + exp_rx1.size(), 0);
        check("readable_idle", readable, 2'b00);
        check("read_data_idle", read_data, '0);
        @(posedge CLK); #1;
    endtask

    task automatic tx_write(input logic [1:0] mask, input logic [4:0] len, input logic [71:0] pl);
        logic [4:0] cl = (int'(len) > MAXLEN) ? 5'(MAXLEN) : len;
        check("writable", writable, {mdl_tx1.size() < FIFO_DEPTH, mdl_tx0.size() < FIFO_DEPTH});
        write_flag = mask;
        write_data = {len, pl};
        @(posedge CLK); #1;
        write_flag = '0;
        if (mask[0] && mdl_tx0.size() < FIFO_DEPTH) mdl_tx0.push_back({cl, pl});
        if (mask[1] && mdl_tx1.size() < FIFO_DEPTH) mdl_tx1.push_back({cl, pl});
    endtask

    // Turns the queued messages into the expected byte stream in arbitration order.
    task automatic tx_plan();
        logic [W-1:0] m;
        logic [4:0]   l;
        int           pick;
        while (mdl_tx0.size() + mdl_tx1.size() != 0) begin
`ifdef MULTICHAN_LINK_RR_EN
            pick = (rr_last + 1) % NCH;
            if ((pick == 0 && mdl_tx0.size() == 0) || (pick == 1 && mdl_tx1.size() == 0))
                pick = (pick + 1) % NCH;
`else
            pick = (mdl_tx0.size() != 0) ? 0 : 1;
`endif
            rr_last = pick;
            if (pick == 0) m = mdl_tx0.pop_front();
            else m = mdl_tx1.pop_front();
            l = m[W-1 -: LENGTH_BIT];
            exp_tx.push_back({3'(pick), l});
            for (int k = 0; k < int'(l); k++) exp_tx.push_back(m[8*k +: 8]);
        end
    endtask

    task automatic tx_wait();
        int t = 0;
        while (exp_tx.size() != 0 && t < 2000) begin
            @(posedge CLK); #1;
            sendable = ($urandom_range(3) != 0);
            t++;
        end
        check("tx_drained", exp_tx.size(), 0);
        sendable = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        sendable = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [2:0] ch;
        int         r;
        RST        = 1'b1;
        sendable   = 1'b0;
        recvable   = 1'b0;
        recv_data  = '0;
        write_flag = '0;
        write_data = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_send_flag", send_flag, 1'b0);
        check("rst_send_data", send_data, 8'h00);
        check("rst_recv_flag", recv_flag, 1'b0);
        check("rst_readable", readable, 2'b00);
        check("rst_writable", writable, 2'b11);
        check("rst_read_data", read_data, '0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // RX read request: 05,00,10,00,00,00
        rx_msg(3'd0, 5'd5, 72'h00_0000_1000);
        @(negedge CLK);
        check("req_readable", readable, 2'b01);
        check("req_read_data", read_data, {5'd5, 72'h00_0000_1000});
        @(posedge CLK); #1;
        rx_drain_all();

        // Channel 1 arrives first, channel 0 must still be presented first.
        rx_msg(3'd1, 5'd1, 72'hAA);
        rx_msg(3'd0, 5'd1, 72'hBB);
        @(negedge CLK);
        check("prio_readable", readable, 2'b11);
        check("prio_read_data", read_data, {5'd1, 72'hBB});
        @(posedge CLK); #1;
        rx_drain_all();

        // Drops: oversized length, out-of-range channel; then a zero-length message.
        rx_msg(3'd0, 5'd10, rand72());
        rx_msg(3'd7, 5'd2, rand72());
        rx_msg(3'd0, 5'd1, 72'h55);
        rx_msg(3'd1, 5'd0, 72'h0);
        rx_drain_all();

        // Overfill channel 0: the fifth message is dropped.
        for (int n = 0; n < 5; n++) rx_msg(3'd0, 5'($urandom_range(0, MAXLEN)), rand72());
        @(negedge CLK);
        check("fill_readable", readable, 2'b01);
        check("fill_writable", writable, 2'b11);
        @(posedge CLK); #1;
        rx_drain_all();

        // Random RX traffic.
        for (int round = 0; round < 4; round++) begin
            for (int n = 0; n < 8; n++) begin
                r  = $urandom_range(5);
                ch = (r < 2) ? 3'd0 : (r < 4) ? 3'd1 : (r == 4) ? 3'd2 : 3'd7;
                rx_msg(ch, 5'($urandom_range(0, 12)), rand72());
            end
            rx_drain_all();
        end

        // TX reply with a two-cycle sendable stall mid-frame.
        sendable = 1'b1;
        tx_write(2'b01, 5'd4, 72'hDEAD_BEEF);
        tx_plan();
        repeat (3) @(posedge CLK);
        #1;
        sendable = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        sendable = 1'b1;
        tx_wait();

        // Arbitration: two messages queued on each channel.
        tx_write(2'b11, 5'd2, 72'h1111);
        tx_write(2'b11, 5'd3, 72'h22_2222);
        tx_plan();
        tx_wait();

        // Random TX traffic, including clamped lengths and writes to full FIFOs.
        for (int round = 0; round < 5; round++) begin
            for (int n = 0; n < int'($urandom_range(2, 9)); n++)
                tx_write(2'($urandom_range(1, 3)), 5'($urandom_range(0, 12)), rand72());
            tx_plan();
            tx_wait();
        end

        // Reset in the middle of a TX frame and a partial RX message.
        tx_mon_en = 1'b0;
        sendable  = 1'b1;
        tx_write(2'b01, 5'd9, rand72());
        repeat (3) @(posedge CLK);
        #1;
        feed_byte(8'h03);
        feed_byte(8'h11);
        recvable  = 1'b1;
        recv_data = 8'h22;
        RST       = 1'b1;
        #2;
        check("mid_rst_send_flag", send_flag, 1'b0);
        check("mid_rst_send_data", send_data, 8'h00);
        check("mid_rst_recv_flag", recv_flag, 1'b0);
        check("mid_rst_readable", readable, 2'b00);
        check("mid_rst_writable", writable, 2'b11);
        check("mid_rst_read_data", read_data, '0);
        @(posedge CLK); #1;
        RST      = 1'b0;
        recvable = 1'b0;
        mdl_tx0.delete();
        mdl_tx1.delete();
        exp_tx.delete();
        rr_last   = NCH - 1;
        tx_mon_en = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        sendable = 1'b0;
        rx_msg(3'd1, 5'd2, 72'h3C5A);
        rx_drain_all();
        tx_write(2'b10, 5'd1, 72'h77);
        tx_write(2'b01, 5'd1, 72'h66);
        tx_plan();
        tx_wait();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
